// File: rtl/pc_fetch_ctrl.sv
// Program counter and next-PC sequencer with an instruction-memory req/ready handshake.
// Redirects seen while a fetch is outstanding are held until the fetch completes.
module pc_fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0040_0004
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        exc,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic [31:0] pc_plus4,
    input  logic        imem_ready,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        fetch_valid,
    output logic        misalign
);

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [31:0] pc_q;
    logic        pend_valid;
    logic [1:0]  pend_lvl;
    logic [31:0] pend_target;
    logic        misalign_q;

    logic [1:0]  req_lvl;
    logic [31:0] req_target;
    logic [1:0]  held_lvl;
    logic        redirect;
    logic [31:0] target;
    logic        bad_align;
    logic [31:0] pc_next;
    logic        fire;

    // Request level: 3 = exc, 2 = jmp, 1 = branch, 0 = none.
    always_comb begin
        req_lvl    = 2'd0;
        req_target = '0;
        if (exc) begin
            req_lvl    = 2'd3;
            req_target = EXC_VECTOR;
        end else if (jmp) begin
            req_lvl    = 2'd2;
            req_target = jmp_target;
        end else if (br_taken) begin
            req_lvl    = 2'd1;
            req_target = br_target;
        end
    end

    assign held_lvl = pend_valid ? pend_lvl : 2'd0;

    always_comb begin
        redirect = 1'b1;
        target   = pc_plus4;
        if (req_lvl == 2'd3) begin
            target = EXC_VECTOR;
        end else if (pend_valid) begin
            target = pend_target;
        end else if (req_lvl != 2'd0) begin
            target = req_target;
        end else begin
            redirect = 1'b0;
        end
    end

    assign bad_align = redirect & (target[1:0] != 2'b00);
    assign pc_next   = bad_align ? EXC_VECTOR : target;

    always_comb begin
        state_nx = state;
        imem_req = 1'b0;
        unique case (state)
            BOOT:  state_nx = FETCH;
            FETCH: begin
                imem_req = ~stall;
                if (stall) state_nx = HOLD;
            end
            HOLD:  if (!stall) state_nx = FETCH;
            default: state_nx = BOOT;
        endcase
    end

    assign fire        = imem_req & imem_ready;
    assign fetch_valid = fire;
    assign pc          = pc_q;
    assign imem_addr   = pc_q;
    assign misalign    = misalign_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BOOT;
            pc_q        <= RESET_PC;
            pend_valid  <= 1'b0;
            pend_lvl    <= 2'd0;
            pend_target <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state      <= state_nx;
            misalign_q <= fire & bad_align;
            if (fire) begin
                pc_q       <= pc_next;
                pend_valid <= 1'b0;
            end else if (req_lvl > held_lvl) begin
                // Only a strictly stronger request may replace a held one.
                pend_valid  <= 1'b1;
                pend_lvl    <= req_lvl;
                pend_target <= req_target;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: stimulus pushes expected fetch addresses,
// a monitor pops and compares on every completed fetch.
module tb_pc_fetch_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        exc;
    logic        jmp;
    logic [31:0] jmp_target;
    logic        br_taken;
    logic [31:0] br_target;
    logic [31:0] pc_plus4;
    logic        imem_ready;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        fetch_valid;
    logic        misalign;

    int total;
    int bad;

    typedef struct packed {
        logic [31:0] addr;
        logic        mis;
    } exp_t;

    exp_t sb[$];

    pc_fetch_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .stall      (stall),
        .exc        (exc),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .pc_plus4   (pc_plus4),
        .imem_ready (imem_ready),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .fetch_valid(fetch_valid),
        .misalign   (misalign)
    );

    // Stand-in for the external cla32 adder.
    assign pc_plus4 = pc + 32'd4;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && fetch_valid) begin
            exp_t e;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_fetch addr=%h", imem_addr);
            end else begin
                e = sb.pop_front();
                if (imem_addr !== e.addr || misalign !== e.mis) begin
                    bad++;
                    $display("FAIL fetch got addr=%h mis=%b want addr=%h mis=%b",
                             imem_addr, misalign, e.addr, e.mis);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic rdy, input logic fires,
                       input logic [31:0] addr, input logic mis);
        exp_t e;
        imem_ready = rdy;
        if (fires) begin
            e.addr = addr;
            e.mis  = mis;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        exc      = 1'b0;
        jmp      = 1'b0;
        br_taken = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        rst_n      = 1'b0;
        stall      = 1'b0;
        exc        = 1'b0;
        jmp        = 1'b0;
        br_taken   = 1'b0;
        jmp_target = '0;
        br_target  = '0;
        imem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pc", pc, 32'h0040_0000);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_mis", {31'd0, misalign}, 32'd0);
        rst_n = 1'b1;
        #1;
        chk("boot_req", {31'd0, imem_req}, 32'd0);
        cyc(1'b1, 1'b0, '0, 1'b0);

        // T1
        cyc(1'b1, 1'b1, 32'h0040_0000, 1'b0);
        cyc(1'b1, 1'b1, 32'h0040_0004, 1'b0);
        chk("t1_pc", pc, 32'h0040_0008);

        // T2 wait states
        for (int i = 0; i < 3; i++) begin
            chk("t2_addr", imem_addr, 32'h0040_0008);
            chk("t2_req", {31'd0, imem_req}, 32'd1);
            cyc(1'b0, 1'b0, '0, 1'b0);
        end
        cyc(1'b1, 1'b1, 32'h0040_0008, 1'b0);
        chk("t2_pc", pc, 32'h0040_000C);

        // T3 priority
        exc = 1'b1; jmp = 1'b1; br_taken = 1'b1;
        jmp_target = 32'h0040_0100; br_target = 32'h0040_0200;
        cyc(1'b1, 1'b1, 32'h0040_000C, 1'b0);
        chk("t3_exc", pc, 32'h0040_0004);
        jmp = 1'b1; br_taken = 1'b1;
        cyc(1'b1, 1'b1, 32'h0040_0004, 1'b0);
        chk("t3_jmp", pc, 32'h0040_0100);

        // T4 pending branch
        br_taken = 1'b1; br_target = 32'h0040_0040;
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0040_0100, 1'b0);
        chk("t4_pend", pc, 32'h0040_0040);
        cyc(1'b1, 1'b1, 32'h0040_0040, 1'b0);

        // T5 stall
        for (int i = 0; i < 4; i++) begin
            stall = 1'b1;
            imem_ready = 1'b1;
            #1;
            chk("t5_req", {31'd0, imem_req}, 32'd0);
            chk("t5_fv", {31'd0, fetch_valid}, 32'd0);
            chk("t5_pc", pc, 32'h0040_0044);
            @(posedge clk);
            #1;
        end
        stall = 1'b0;
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0040_0044, 1'b0);
        chk("t5_pc_after", pc, 32'h0040_0048);

        // T6 misalign then wrap
        jmp = 1'b1; jmp_target = 32'h0040_0102;
        cyc(1'b1, 1'b1, 32'h0040_0048, 1'b0);
        chk("t6_mis_pc", pc, 32'h0040_0004);
        cyc(1'b1, 1'b1, 32'h0040_0004, 1'b1);
        cyc(1'b1, 1'b1, 32'h0040_0008, 1'b0);
        jmp = 1'b1; jmp_target = 32'hFFFF_FFFC;
        cyc(1'b1, 1'b1, 32'h0040_000C, 1'b0);
        chk("t6_top", pc, 32'hFFFF_FFFC);
        cyc(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        chk("t6_wrap", pc, 32'h0000_0000);
        cyc(1'b1, 1'b1, 32'h0000_0000, 1'b0);

        // exc overrides a held branch; a later jmp is weaker and ignored
        br_taken = 1'b1; br_target = 32'h0000_0100;
        cyc(1'b0, 1'b0, '0, 1'b0);
        exc = 1'b1;
        cyc(1'b0, 1'b0, '0, 1'b0);
        jmp = 1'b1; jmp_target = 32'h0000_0200;
        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0000_0004, 1'b0);
        chk("pend_exc", pc, 32'h0040_0004);

        // reset mid-fetch drops request and pending jump
        jmp = 1'b1; jmp_target = 32'h0000_0300;
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("mid_req", {31'd0, imem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req", {31'd0, imem_req}, 32'd0);
        chk("mid_rst_pc", pc, 32'h0040_0000);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc(1'b1, 1'b0, '0, 1'b0);
        cyc(1'b1, 1'b1, 32'h0040_0000, 1'b0);
        chk("post_rst_pc", pc, 32'h0040_0004);

        cyc(1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, 1'b0, '0, 1'b0);
        chk("sb_empty", sb.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
